// File: rtl/bit_scan_pkg.sv
// Shared definitions for the bit-scan sequencer.
//
// Contents:
//    state_t   - sequencer state encoding (ST_IDLE, ST_DRAIN)
//    BSR_WIDTH - default request vector width
//
// Optional feature macro used by the sequencer: BIT_SCAN_SEQ_ZERO_BEAT_EN
package bit_scan_pkg;

   // Sequencer states: idle waits for a vector; drain emits one set bit per beat.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   localparam int BSR_WIDTH = 4;

endpackage : bit_scan_pkg

// File: rtl/bit_scan_sequencer_encoder.sv
// msb_index_encoder: combinational most-significant-set-bit encoder.
//
// Ports:
//    vec  in   WIDTH  vector to scan
//    idx  out  IDX_W  index of the highest set bit (0 when vec is zero)
//    mask out  WIDTH  one-hot mask of that bit (all zero when vec is zero)
module msb_index_encoder
   import bit_scan_pkg::*;
#(
   parameter int WIDTH = BSR_WIDTH,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic [WIDTH-1:0] mask
);

   // Scan upward so the last set bit seen, i.e. the highest, is the one kept.
   always_comb begin
      idx  = '0;
      mask = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (vec[i]) begin
            idx     = IDX_W'(i);
            mask    = '0;
            mask[i] = 1'b1;
         end
      end
   end

endmodule : msb_index_encoder

// File: rtl/bit_scan_sequencer.sv
// bit_scan_sequencer: accepts a request vector over a valid/ready handshake
// and drains it one set bit per output beat, highest index first.
//
// Ports:
//    clk        in   1      rising-edge clock
//    rst        in   1      synchronous reset, active-high
//    in_valid   in   1      in_vec is presented
//    in_ready   out  1      block accepts in_vec this cycle
//    in_vec     in   WIDTH  request vector, bit WIDTH-1 highest priority
//    out_valid  out  1      out_idx/out_last are valid
//    out_ready  in   1      consumer takes the current beat
//    out_idx    out  IDX_W  index of highest pending set bit
//    out_last   out  1      current beat is the final bit of this vector
//    busy       out  1      a vector is being drained
//    out_zero   out  1      (BIT_SCAN_SEQ_ZERO_BEAT_EN only) beat stands for an all-zero vector
//
// Optional feature macro: BIT_SCAN_SEQ_ZERO_BEAT_EN. When defined, an accepted
// all-zero vector produces a single beat flagged by out_zero instead of being
// silently consumed.
module bit_scan_sequencer
   import bit_scan_pkg::*;
#(
   parameter int WIDTH = BSR_WIDTH,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             busy
`ifdef BIT_SCAN_SEQ_ZERO_BEAT_EN
   ,
   output logic             out_zero
`endif
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic [WIDTH-1:0] clr_mask;
   logic [IDX_W-1:0] enc_idx;
   logic             draining;
   logic             last_bit;

   msb_index_encoder #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_encoder (
      .vec  (pending_q),
      .idx  (enc_idx),
      .mask (clr_mask)
   );

   // Output side is purely a function of the registered pending vector, so
   // it holds steady for as long as the consumer stalls.
   always_comb begin
      draining  = (state_q == ST_DRAIN);
      last_bit  = ((pending_q & ~clr_mask) == '0);
      out_valid = draining;
      busy      = draining;
      out_idx   = enc_idx;
      // last_bit is trivially true on an empty idle vector; gate it so
      // out_last only ever qualifies a real beat.
      out_last  = draining && last_bit;
      // Accept a new vector while idle, or in the same cycle the final beat
      // leaves, so consecutive vectors drain without an idle gap.
      in_ready  = !draining || (out_ready && last_bit);
`ifdef BIT_SCAN_SEQ_ZERO_BEAT_EN
      out_zero  = draining && (pending_q == '0);
`endif
   end

   // Next-state logic: clear the emitted bit on each accepted beat, then let
   // a new vector (if one is accepted this cycle) override the result.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      if (draining && out_ready) begin
         pending_d = pending_q & ~clr_mask;
         if (last_bit) begin
            state_d = ST_IDLE;
         end
      end
      if (in_ready && in_valid) begin
         pending_d = in_vec;
`ifdef BIT_SCAN_SEQ_ZERO_BEAT_EN
         state_d   = ST_DRAIN;
`else
         state_d   = (in_vec != '0) ? ST_DRAIN : ST_IDLE;
`endif
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
   end

endmodule : bit_scan_sequencer

// File: tb/tb_bit_scan_sequencer.sv
// Self-checking bench for bit_scan_sequencer (WIDTH=4).
// Directed steps drive vectors; expected beats go into a scoreboard queue and
// a negedge monitor pops and compares each beat the DUT hands over.
module tb_bit_scan_sequencer;

   localparam int W  = 4;
   localparam int IW = 2;

   typedef struct {
      int idx;
      bit last;
      bit zero;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_vec = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [IW-1:0] out_idx;
   logic          out_last;
   logic          busy;
`ifdef BIT_SCAN_SEQ_ZERO_BEAT_EN
   logic          out_zero;
`endif

   int    checks   = 0;
   int    failures = 0;
   beat_t sbQ[$];

   bit_scan_sequencer #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy)
`ifdef BIT_SCAN_SEQ_ZERO_BEAT_EN
      ,
      .out_zero  (out_zero)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference model: one beat per set bit, highest first; last when no lower bits remain.
   task automatic pushExpected(input logic [W-1:0] v);
      beat_t b;
      for (int i = W - 1; i >= 0; i--) begin
         if (v[i]) begin
            b.idx  = i;
            b.last = ((v & ((4'b0001 << i) - 4'b0001)) == 4'b0000);
            b.zero = 1'b0;
            sbQ.push_back(b);
         end
      end
`ifdef BIT_SCAN_SEQ_ZERO_BEAT_EN
      if (v == '0) begin
         b.idx  = 0;
         b.last = 1'b1;
         b.zero = 1'b1;
         sbQ.push_back(b);
      end
`endif
   endtask

   // Present a vector and hold it until the handshake edge; returns at that edge + 1.
   task automatic applyStimulus(input logic [W-1:0] v);
      bit done = 1'b0;
      in_valid = 1'b1;
      in_vec   = v;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
      else pushExpected(v);
      in_valid = 1'b0;
   endtask

   // Wait until all expected beats are consumed and the DUT is idle.
   task automatic waitDrain(input bit toggleReady);
      bit done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         if (sbQ.size() == 0 && !out_valid) done = 1'b1;
         @(posedge clk);
         #1;
         if (toggleReady) out_ready = ~out_ready;
      end
      out_ready = 1'b1;
      if (!done) checkOutput("drain_timeout", 32'd0, 32'd1);
   endtask

   // Monitor: transferred beats are popped and compared; stalled beats must
   // match the head of the scoreboard without consuming it.
   always @(negedge clk) begin
      if (out_valid) begin
         checkOutput("beat_expected", (sbQ.size() != 0), 32'd1);
         if (sbQ.size() != 0) begin
            checkOutput("beat_idx", out_idx, sbQ[0].idx);
            checkOutput("beat_last", out_last, sbQ[0].last);
`ifdef BIT_SCAN_SEQ_ZERO_BEAT_EN
            checkOutput("beat_zero", out_zero, sbQ[0].zero);
`endif
            if (out_ready) void'(sbQ.pop_front());
         end
      end
   end

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst_out_valid", out_valid, 32'd0);
      checkOutput("rst_out_idx", out_idx, 32'd0);
      checkOutput("rst_out_last", out_last, 32'd0);
      checkOutput("rst_busy", busy, 32'd0);
      checkOutput("rst_in_ready", in_ready, 32'd1);

      // 1010 with continuous ready: beats 3 then 1
      applyStimulus(4'b1010);
      waitDrain(1'b0);
      checkOutput("t1_busy", busy, 32'd0);
      checkOutput("t1_in_ready", in_ready, 32'd1);

      // 1111 with ready toggling: each index held through stalls
      applyStimulus(4'b1111);
      waitDrain(1'b1);
      checkOutput("t2_idle", out_valid, 32'd0);

      // Back-to-back 0001 then 0100 with no bubble
      applyStimulus(4'b0001);
      applyStimulus(4'b0100);
      checkOutput("b2b_valid", out_valid, 32'd1);
      checkOutput("b2b_idx", out_idx, 32'd2);
      waitDrain(1'b0);

      // All-zero vector
      applyStimulus(4'b0000);
`ifdef BIT_SCAN_SEQ_ZERO_BEAT_EN
      checkOutput("zero_valid", out_valid, 32'd1);
      waitDrain(1'b0);
`else
      for (int c = 0; c < 3; c++) begin
         checkOutput("zero_no_beat", out_valid, 32'd0);
         checkOutput("zero_in_ready", in_ready, 32'd1);
         @(posedge clk);
         #1;
      end
`endif

      // Reset during the second beat of 1100
      applyStimulus(4'b1100);
      @(posedge clk);
      #1;
      checkOutput("mid_rst_beat2", out_idx, 32'd2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("mid_rst_valid", out_valid, 32'd0);
      checkOutput("mid_rst_in_ready", in_ready, 32'd1);
      checkOutput("mid_rst_sb_empty", sbQ.size(), 32'd0);
      rst = 1'b0;
      applyStimulus(4'b0010);
      waitDrain(1'b0);

      // Vector presented while busy and not ready is ignored
      out_ready = 1'b0;
      applyStimulus(4'b1011);
      in_valid = 1'b1;
      in_vec   = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         checkOutput("busy_in_ready", in_ready, 32'd0);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      waitDrain(1'b0);
      checkOutput("busy_final_idle", busy, 32'd0);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_bit_scan_sequencer
